fifo_seq_checker: RTL and testbench
===================================

// Module: fifo_seq_checker
// PURPOSE
//  Read-side consumer for the asymmetric 1:2 FIFO demo. The write side pushes an
//  incrementing LANE_W-bit count, and the FIFO packs two samples per read word.
//  This block drains the FIFO read port, splits each word into lanes and checks
//  the count sequence. It reports word/error counts and a sticky error for LEDs.
// PARAMETERS
//  LANE_W      16  width of one written sample; read word is 2*LANE_W
//  HI_FIRST    0   1: rdata[2W-1:W] is the earlier sample; 0: rdata[W-1:0] is earlier
//  STOP_ON_ERR 0   1: halt reads on first mismatch; 0: resync and keep checking
// PORTS
//  rd_clk            in   1         read-domain clock
//  sys_rst_n         in   1         async active-low reset
//  enable_i          in   1         level; 1 = run, 0 = return to IDLE
//  start_i           in   1         arm trigger (tie to FIFO prog_full_o)
//  clear_i           in   1         1-cycle pulse: clear counters, err_o, capture
//  fifo_rst_busy_i   in   1         FIFO reset busy
//  fifo_empty_i      in   1         FIFO empty
//  fifo_rd_en_o      out  1         FIFO read enable
//  fifo_rdata_i      in   2*LANE_W  FIFO read data
//  fifo_rd_valid_i   in   1         FIFO read data valid
//  locked_o          out  1         sequence acquired (state CHECK)
//  err_o             out  1         sticky mismatch flag
//  word_cnt_o        out  32        valid words checked, wraps mod 2^32
//  err_cnt_o         out  16        mismatched words, saturates at 16'hFFFF
//  first_err_o       out  2*LANE_W  rdata of first mismatch since reset/clear
//  state_o           out  2         0 IDLE, 1 SYNC, 2 CHECK, 3 HALT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, expected count register 0.
//  Lanes: E = earlier lane, L = later lane, selected by HI_FIRST. Arithmetic is
//   mod 2^LANE_W.
//  fifo_rd_en_o = (SYNC|CHECK) & ~fifo_empty_i & ~fifo_rst_busy_i. It is
//   combinational, so there is no read on empty.
//  Read latency is not assumed. Checking keys only on fifo_rd_valid_i.
//   Valid words arriving in IDLE/HALT are ignored and not counted.
//  FSM:
//   IDLE : enable_i & start_i & ~fifo_rst_busy_i -> SYNC.
//   SYNC : on valid, if L==E+1: exp<=L+1, word_cnt++, -> CHECK.
//          Otherwise stay in SYNC; the word is not counted and is not an error.
//   CHECK: on valid, word_cnt++. A match is E==exp & L==exp+1; then exp<=exp+2.
//          On mismatch: err_cnt++ (saturating), err_o<=1, and first_err_o captures
//          rdata if err_cnt was 0. Then exp<=L+1 (resync, so one dropped word
//          costs one error). If STOP_ON_ERR=1 -> HALT.
//   HALT : no reads; hold all outputs.
//   Any state & ~enable_i -> IDLE next cycle. Counters and err_o hold.
//  clear_i wins over a same-cycle count/error update. The state is unchanged.
//  start_i is only sampled in IDLE, so later prog_full toggles are don't-care.
//  fifo_rst_busy_i rising mid-run blocks rd_en. The state is kept and in-flight
//   valid words are still checked.
//  Async reset mid-burst returns to the reset values immediately.
// TESTING
//  1. Hold sys_rst_n=0, then release with enable_i=0 -> outputs 0, state_o=0,
//     fifo_rd_en_o=0.
//  2. HI_FIRST=0, W=16, feed words 32'h0001_0000, 32'h0003_0002, ... (100 words)
//     -> locked_o=1, word_cnt_o=100, err_cnt_o=0.
//  3. Wrap: feed 32'hFFFF_FFFE then 32'h0001_0000 -> err_cnt_o stays 0.
//  4. Drop 32'h0005_0004 from the stream -> err_cnt_o=1, err_o=1,
//     first_err_o=32'h0007_0006; later words produce no further errors.
//  5. fifo_empty_i=1 while one read is in flight -> rd_en_o=0 that cycle, and
//     the in-flight word is still counted.
//  6. STOP_ON_ERR=1 with a corrupted word -> state_o=3, rd_en_o=0. Then drop
//     enable_i -> state_o=0; pulse clear_i -> counters 0.

Source files
------------

// File: rtl/fifo_seq_checker.sv
// Read-side consumer for the asymmetric 1:2 FIFO demo: drains the FIFO, splits each
// word into an earlier/later lane and checks that the samples form an incrementing count.
module fifo_seq_checker #(
  parameter int unsigned LANE_W      = 16,
  parameter bit          HI_FIRST    = 1'b0,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                  rd_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic                  fifo_rst_busy_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [2*LANE_W-1:0]   fifo_rdata_i,
  input  logic                  fifo_rd_valid_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [31:0]           word_cnt_o,
  output logic [15:0]           err_cnt_o,
  output logic [2*LANE_W-1:0]   first_err_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     exp_q, exp_d;
  logic [31:0]           wordCnt_q, wordCnt_d;
  logic [15:0]           errCnt_q, errCnt_d;
  logic                  err_q, err_d;
  logic [2*LANE_W-1:0]   firstErr_q, firstErr_d;

  logic [LANE_W-1:0]     laneE, laneL;
  logic                  syncHit, checkHit;

  always_comb begin
    if (HI_FIRST) begin
      laneE = fifo_rdata_i[2*LANE_W-1:LANE_W];
      laneL = fifo_rdata_i[LANE_W-1:0];
    end else begin
      laneE = fifo_rdata_i[LANE_W-1:0];
      laneL = fifo_rdata_i[2*LANE_W-1:LANE_W];
    end
  end

  // Lane arithmetic wraps at LANE_W bits so the count rolls over cleanly.
  assign syncHit  = (laneL == laneE + LANE_W'(1));
  assign checkHit = (laneE == exp_q) && (laneL == exp_q + LANE_W'(1));

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    wordCnt_d  = wordCnt_q;
    errCnt_d   = errCnt_q;
    err_d      = err_q;
    firstErr_d = firstErr_q;

    unique case (state_q)
      IDLE: begin
        if (enable_i && start_i && !fifo_rst_busy_i) state_d = SYNC;
      end
      SYNC: begin
        if (fifo_rd_valid_i && syncHit) begin
          exp_d     = laneL + LANE_W'(1);
          wordCnt_d = wordCnt_q + 32'd1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (fifo_rd_valid_i) begin
          wordCnt_d = wordCnt_q + 32'd1;
          if (checkHit) begin
            exp_d = exp_q + LANE_W'(2);
          end else begin
            if (errCnt_q != 16'hFFFF) errCnt_d = errCnt_q + 16'd1;
            if (errCnt_q == 16'd0) firstErr_d = fifo_rdata_i;
            err_d = 1'b1;
            // Resync on the bad word so a single dropped word costs one error.
            exp_d = laneL + LANE_W'(1);
            if (STOP_ON_ERR) state_d = HALT;
          end
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase

    if (!enable_i) state_d = IDLE;

    if (clear_i) begin
      wordCnt_d  = '0;
      errCnt_d   = '0;
      err_d      = 1'b0;
      firstErr_d = '0;
    end
  end

  always_ff @(posedge rd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      wordCnt_q  <= '0;
      errCnt_q   <= '0;
      err_q      <= 1'b0;
      firstErr_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      wordCnt_q  <= wordCnt_d;
      errCnt_q   <= errCnt_d;
      err_q      <= err_d;
      firstErr_q <= firstErr_d;
    end
  end

  assign fifo_rd_en_o = ((state_q == SYNC) || (state_q == CHECK)) &&
                        !fifo_empty_i && !fifo_rst_busy_i;
  assign locked_o     = (state_q == CHECK);
  assign err_o        = err_q;
  assign word_cnt_o   = wordCnt_q;
  assign err_cnt_o    = errCnt_q;
  assign first_err_o  = firstErr_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Bench for fifo_seq_checker: instance A (HI_FIRST=0, resync) is fed from a FIFO model
// with a scoreboard; instance B (HI_FIRST=1, STOP_ON_ERR=1) is driven cycle by cycle.
module tb_fifo_seq_checker;
  localparam int W = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic sysRstN;

  logic enableA, startA, clearA, busyA, emptyA, rdEnA, validA, lockedA, errA;
  logic [2*W-1:0] rdataA, firstErrA;
  logic [31:0] wordCntA;
  logic [15:0] errCntA;
  logic [1:0] stateA;

  logic enableB, startB, clearB, busyB, emptyB, rdEnB, validB, lockedB, errB;
  logic [2*W-1:0] rdataB, firstErrB;
  logic [31:0] wordCntB;
  logic [15:0] errCntB;
  logic [1:0] stateB;

  fifo_seq_checker #(.LANE_W(W), .HI_FIRST(1'b0), .STOP_ON_ERR(1'b0)) dutA (
    .rd_clk(clock), .sys_rst_n(sysRstN), .enable_i(enableA), .start_i(startA),
    .clear_i(clearA), .fifo_rst_busy_i(busyA), .fifo_empty_i(emptyA),
    .fifo_rd_en_o(rdEnA), .fifo_rdata_i(rdataA), .fifo_rd_valid_i(validA),
    .locked_o(lockedA), .err_o(errA), .word_cnt_o(wordCntA), .err_cnt_o(errCntA),
    .first_err_o(firstErrA), .state_o(stateA)
  );

  fifo_seq_checker #(.LANE_W(W), .HI_FIRST(1'b1), .STOP_ON_ERR(1'b1)) dutB (
    .rd_clk(clock), .sys_rst_n(sysRstN), .enable_i(enableB), .start_i(startB),
    .clear_i(clearB), .fifo_rst_busy_i(busyB), .fifo_empty_i(emptyB),
    .fifo_rd_en_o(rdEnB), .fifo_rdata_i(rdataB), .fifo_rd_valid_i(validB),
    .locked_o(lockedB), .err_o(errB), .word_cnt_o(wordCntB), .err_cnt_o(errCntB),
    .first_err_o(firstErrB), .state_o(stateB)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int unsigned words;
    int unsigned errs;
  } exp_t;

  exp_t expQ[$];
  logic [2*W-1:0] srcQ[$];

  bit mLocked;
  logic [W-1:0] mExp;
  int unsigned mWords, mErrs;

  task automatic modelReset();
    mLocked = 1'b0;
    mExp = '0;
    mWords = 0;
    mErrs = 0;
    srcQ.delete();
    expQ.delete();
  endtask

  // Queue one word for the FIFO model and record the counts expected once it is consumed.
  task automatic applyStimulus(input logic [2*W-1:0] word);
    logic [W-1:0] e, l;
    exp_t x;
    e = word[W-1:0];
    l = word[2*W-1:W];
    if (!mLocked) begin
      if (l == e + 16'd1) begin
        mLocked = 1'b1;
        mExp = l + 16'd1;
        mWords++;
      end
    end else begin
      mWords++;
      if (e == mExp && l == mExp + 16'd1) begin
        mExp = mExp + 16'd2;
      end else begin
        mErrs++;
        mExp = l + 16'd1;
      end
    end
    srcQ.push_back(word);
    x.words = mWords;
    x.errs = mErrs;
    expQ.push_back(x);
  endtask

  task automatic doReset();
    sysRstN = 1'b0;
    enableA = 1'b0; startA = 1'b0; clearA = 1'b0; busyA = 1'b0; emptyA = 1'b1;
    validA = 1'b0; rdataA = '0;
    enableB = 1'b0; startB = 1'b0; clearB = 1'b0; busyB = 1'b0; emptyB = 1'b1;
    validB = 1'b0; rdataB = '0;
    modelReset();
    repeat (2) @(negedge clock);
    sysRstN = 1'b1;
    @(negedge clock);
  endtask

  task automatic armA();
    enableA = 1'b1;
    startA = 1'b1;
    @(negedge clock);
    total++;
    if (stateA !== 2'd1) begin bad++; $display("[TB] FAIL armA state: got %0d expected 1", stateA); end
  endtask

  // FIFO model with one cycle read latency; emptyAt forces empty on one cycle.
  task automatic runWords(input int emptyAt, input int budget);
    bit pending, consumed;
    logic [2*W-1:0] pendWord;
    int cyc;
    exp_t e;
    pending = 1'b0;
    consumed = 1'b0;
    pendWord = '0;
    cyc = 0;
    while ((srcQ.size() > 0 || pending || consumed) && cyc < budget) begin
      @(negedge clock);
      if (consumed) begin
        e = expQ.pop_front();
        total++;
        if (wordCntA !== e.words) begin bad++; $display("[TB] FAIL sb word_cnt: got %0d expected %0d", wordCntA, e.words); end
        total++;
        if (errCntA !== 16'(e.errs)) begin bad++; $display("[TB] FAIL sb err_cnt: got %0d expected %0d", errCntA, e.errs); end
      end
      validA = pending;
      rdataA = pending ? pendWord : '0;
      consumed = pending;
      emptyA = (srcQ.size() == 0) || (cyc == emptyAt);
      #1;
      if (cyc == emptyAt) begin
        total++;
        if (rdEnA !== 1'b0) begin bad++; $display("[TB] FAIL rd_en_on_empty: got %b expected 0", rdEnA); end
      end
      pending = 1'b0;
      if (rdEnA === 1'b1) begin
        if (srcQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL rd_en_underflow: got 1 expected 0");
        end else begin
          pendWord = srcQ.pop_front();
          pending = 1'b1;
        end
      end
      cyc++;
    end
    emptyA = 1'b1;
    if (cyc >= budget) begin
      total++; bad++;
      $display("[TB] FAIL run_timeout: got %0d cycles expected < %0d", cyc, budget);
    end
  endtask

  task automatic test_reset();
    sysRstN = 1'b0;
    enableA = 1'b0; startA = 1'b0; clearA = 1'b0; busyA = 1'b0; emptyA = 1'b0;
    validA = 1'b0; rdataA = '0;
    enableB = 1'b0; startB = 1'b0; clearB = 1'b0; busyB = 1'b0; emptyB = 1'b0;
    validB = 1'b0; rdataB = '0;
    repeat (3) @(negedge clock);
    sysRstN = 1'b1;
    @(negedge clock);
    total++; if (stateA !== 2'd0) begin bad++; $display("[TB] FAIL reset state: got %0d expected 0", stateA); end
    total++; if (rdEnA !== 1'b0) begin bad++; $display("[TB] FAIL reset rd_en: got %b expected 0", rdEnA); end
    total++; if (lockedA !== 1'b0) begin bad++; $display("[TB] FAIL reset locked: got %b expected 0", lockedA); end
    total++; if (errA !== 1'b0) begin bad++; $display("[TB] FAIL reset err: got %b expected 0", errA); end
    total++; if (wordCntA !== 32'd0) begin bad++; $display("[TB] FAIL reset word_cnt: got %0d expected 0", wordCntA); end
    total++; if (errCntA !== 16'd0) begin bad++; $display("[TB] FAIL reset err_cnt: got %0d expected 0", errCntA); end
    total++; if (firstErrA !== '0) begin bad++; $display("[TB] FAIL reset first_err: got %h expected 0", firstErrA); end
    total++; if (stateB !== 2'd0 || rdEnB !== 1'b0) begin bad++; $display("[TB] FAIL reset B: got state %0d rd_en %b expected 0 0", stateB, rdEnB); end
  endtask

  task automatic test_stream();
    doReset();
    armA();
    applyStimulus(32'h1234_5678);
    for (int k = 0; k < 100; k++) applyStimulus({16'(2*k + 1), 16'(2*k)});
    runWords(-1, 1000);
    total++; if (lockedA !== 1'b1) begin bad++; $display("[TB] FAIL stream locked: got %b expected 1", lockedA); end
    total++; if (wordCntA !== 32'd100) begin bad++; $display("[TB] FAIL stream word_cnt: got %0d expected 100", wordCntA); end
    total++; if (errCntA !== 16'd0) begin bad++; $display("[TB] FAIL stream err_cnt: got %0d expected 0", errCntA); end
  endtask

  task automatic test_wrap();
    doReset();
    armA();
    applyStimulus(32'hFFFF_FFFE);
    applyStimulus(32'h0001_0000);
    applyStimulus(32'h0003_0002);
    runWords(-1, 100);
    total++; if (errCntA !== 16'd0) begin bad++; $display("[TB] FAIL wrap err_cnt: got %0d expected 0", errCntA); end
    total++; if (wordCntA !== 32'd3) begin bad++; $display("[TB] FAIL wrap word_cnt: got %0d expected 3", wordCntA); end
  endtask

  task automatic test_drop();
    doReset();
    armA();
    applyStimulus(32'h0001_0000);
    applyStimulus(32'h0003_0002);
    applyStimulus(32'h0007_0006);
    applyStimulus(32'h0009_0008);
    applyStimulus(32'h000B_000A);
    runWords(-1, 100);
    total++; if (errA !== 1'b1) begin bad++; $display("[TB] FAIL drop err: got %b expected 1", errA); end
    total++; if (errCntA !== 16'd1) begin bad++; $display("[TB] FAIL drop err_cnt: got %0d expected 1", errCntA); end
    total++; if (firstErrA !== 32'h0007_0006) begin bad++; $display("[TB] FAIL drop first_err: got %h expected 00070006", firstErrA); end
  endtask

  task automatic test_empty_in_flight();
    doReset();
    armA();
    for (int k = 0; k < 20; k++) applyStimulus({16'(2*k + 1), 16'(2*k)});
    runWords(5, 500);
    total++; if (wordCntA !== 32'd20) begin bad++; $display("[TB] FAIL empty word_cnt: got %0d expected 20", wordCntA); end
  endtask

  task automatic test_busy();
    emptyA = 1'b0;
    busyA = 1'b1;
    #1;
    total++; if (rdEnA !== 1'b0) begin bad++; $display("[TB] FAIL busy rd_en: got %b expected 0", rdEnA); end
    busyA = 1'b0;
    #1;
    total++; if (rdEnA !== 1'b1) begin bad++; $display("[TB] FAIL unbusy rd_en: got %b expected 1", rdEnA); end
    emptyA = 1'b1;
  endtask

  task automatic test_clear();
    @(negedge clock);
    clearA = 1'b1;
    validA = 1'b1;
    rdataA = 32'h0000_0099;
    @(negedge clock);
    clearA = 1'b0;
    total++; if (wordCntA !== 32'd0 || errCntA !== 16'd0) begin bad++; $display("[TB] FAIL clear counts: got %0d/%0d expected 0/0", wordCntA, errCntA); end
    total++; if (errA !== 1'b0) begin bad++; $display("[TB] FAIL clear err: got %b expected 0", errA); end
    total++; if (lockedA !== 1'b1) begin bad++; $display("[TB] FAIL clear locked: got %b expected 1", lockedA); end
    rdataA = 32'h0055_0044;
    @(negedge clock);
    validA = 1'b0;
    total++; if (wordCntA !== 32'd1 || errCntA !== 16'd1) begin bad++; $display("[TB] FAIL post_clear counts: got %0d/%0d expected 1/1", wordCntA, errCntA); end
    total++; if (firstErrA !== 32'h0055_0044) begin bad++; $display("[TB] FAIL post_clear first_err: got %h expected 00550044", firstErrA); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2;
    sysRstN = 1'b0;
    #1;
    total++; if (wordCntA !== 32'd0 || stateA !== 2'd0 || errA !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset: got cnt %0d state %0d err %b expected 0 0 0", wordCntA, stateA, errA);
    end
    @(negedge clock);
    sysRstN = 1'b1;
  endtask

  task automatic test_stop_on_err();
    doReset();
    enableB = 1'b1;
    startB = 1'b1;
    @(negedge clock);
    total++; if (stateB !== 2'd1) begin bad++; $display("[TB] FAIL stop sync: got %0d expected 1", stateB); end
    validB = 1'b1;
    rdataB = 32'h0000_0001;
    @(negedge clock);
    total++; if (stateB !== 2'd2 || wordCntB !== 32'd1) begin bad++; $display("[TB] FAIL stop lock: got %0d/%0d expected 2/1", stateB, wordCntB); end
    rdataB = 32'h0002_0003;
    @(negedge clock);
    total++; if (wordCntB !== 32'd2 || errCntB !== 16'd0) begin bad++; $display("[TB] FAIL stop match: got %0d/%0d expected 2/0", wordCntB, errCntB); end
    rdataB = 32'h0004_0099;
    @(negedge clock);
    emptyB = 1'b0;
    #1;
    total++; if (stateB !== 2'd3) begin bad++; $display("[TB] FAIL stop halt: got %0d expected 3", stateB); end
    total++; if (rdEnB !== 1'b0) begin bad++; $display("[TB] FAIL stop rd_en: got %b expected 0", rdEnB); end
    total++; if (errCntB !== 16'd1 || errB !== 1'b1) begin bad++; $display("[TB] FAIL stop err: got %0d/%b expected 1/1", errCntB, errB); end
    total++; if (firstErrB !== 32'h0004_0099) begin bad++; $display("[TB] FAIL stop first_err: got %h expected 00040099", firstErrB); end
    rdataB = 32'h0004_0005;
    @(negedge clock);
    total++; if (wordCntB !== 32'd3) begin bad++; $display("[TB] FAIL halt ignore: got %0d expected 3", wordCntB); end
    validB = 1'b0;
    enableB = 1'b0;
    @(negedge clock);
    total++; if (stateB !== 2'd0 || wordCntB !== 32'd3 || errCntB !== 16'd1) begin
      bad++; $display("[TB] FAIL disable: got %0d/%0d/%0d expected 0/3/1", stateB, wordCntB, errCntB);
    end
    clearB = 1'b1;
    @(negedge clock);
    clearB = 1'b0;
    total++; if (wordCntB !== 32'd0 || errCntB !== 16'd0 || errB !== 1'b0 || firstErrB !== '0) begin
      bad++; $display("[TB] FAIL stop clear: got %0d/%0d/%b/%h expected 0/0/0/0", wordCntB, errCntB, errB, firstErrB);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_drop();
    test_empty_in_flight();
    test_busy();
    test_clear();
    test_async_reset();
    test_stop_on_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
